// File: rtl/VX_gpu_pkg.sv
// Shared execute-stage definitions: ALU/branch op codes, sizing and the result payload.
package VX_gpu_pkg;

  localparam int unsigned NumThreads = 4;
  localparam int unsigned TidW       = $clog2(NumThreads);
  localparam int unsigned NumWarps   = 4;
  localparam int unsigned WidW       = $clog2(NumWarps);
  localparam int unsigned UuidW      = 44;
  localparam int unsigned RegW       = 5;
  localparam int unsigned OpTypeW    = 4;
  localparam int unsigned OpModW     = 3;

  // op_mod bit that selects the branch decoder instead of the ALU decoder
  localparam int unsigned BrSelBit = 0;

  // ALU op_type codes; kept contiguous so "known" is a single compare
  localparam logic [OpTypeW-1:0] INST_ALU_ADD   = 4'd0;
  localparam logic [OpTypeW-1:0] INST_ALU_SUB   = 4'd1;
  localparam logic [OpTypeW-1:0] INST_ALU_SLT   = 4'd2;
  localparam logic [OpTypeW-1:0] INST_ALU_SLTU  = 4'd3;
  localparam logic [OpTypeW-1:0] INST_ALU_XOR   = 4'd4;
  localparam logic [OpTypeW-1:0] INST_ALU_OR    = 4'd5;
  localparam logic [OpTypeW-1:0] INST_ALU_AND   = 4'd6;
  localparam logic [OpTypeW-1:0] INST_ALU_SLL   = 4'd7;
  localparam logic [OpTypeW-1:0] INST_ALU_SRL   = 4'd8;
  localparam logic [OpTypeW-1:0] INST_ALU_SRA   = 4'd9;
  localparam logic [OpTypeW-1:0] INST_ALU_LUI   = 4'd10;
  localparam logic [OpTypeW-1:0] INST_ALU_AUIPC = 4'd11;

  // Branch op_type codes (valid when op_mod[BrSelBit] is set)
  localparam logic [OpTypeW-1:0] INST_BR_BEQ  = 4'd0;
  localparam logic [OpTypeW-1:0] INST_BR_BNE  = 4'd1;
  localparam logic [OpTypeW-1:0] INST_BR_BLT  = 4'd2;
  localparam logic [OpTypeW-1:0] INST_BR_BGE  = 4'd3;
  localparam logic [OpTypeW-1:0] INST_BR_BLTU = 4'd4;
  localparam logic [OpTypeW-1:0] INST_BR_BGEU = 4'd5;
  localparam logic [OpTypeW-1:0] INST_BR_JAL  = 4'd6;
  localparam logic [OpTypeW-1:0] INST_BR_JALR = 4'd7;

  typedef struct packed {
    logic [NumThreads-1:0][31:0] data;
    logic [RegW-1:0]             rd;
    logic                        wb;
    logic [UuidW-1:0]            uuid;
    logic [WidW-1:0]             wid;
    logic [NumThreads-1:0]       tmask;
    logic [31:0]                 pc;
  } alu_result_t;

  // Payload carried through both pipe stages
  typedef struct packed {
    alu_result_t res;
    logic        is_br;
    logic        taken;
    logic [31:0] dest;
  } alu_stage_t;

  function automatic logic is_alu_op_known(input logic [OpTypeW-1:0] op);
    return op <= INST_ALU_AUIPC;
  endfunction

endpackage

// File: rtl/VX_pipe_register.sv
// One pipeline stage: payload and valid advance when enabled; reset clears only valid.
module VX_pipe_register #(
  parameter int unsigned DataW = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             valid_i,
  input  logic [DataW-1:0] data_i,
  output logic             valid_o,
  output logic [DataW-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [DataW-1:0] data_d, data_q;

  // Hold everything while disabled (stalled)
  always_comb begin
    valid_d = enable_i ? valid_i : valid_q;
    data_d  = enable_i ? data_i  : data_q;
  end

  // Valid register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload register, no reset needed
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/vx_alu_unit.sv
// Execute-stage ALU: per-lane integer ops, branch resolution on lane tid, two-stage
// stall-on-backpressure pipeline. Branch support is built only when ALU_BRANCH_EN is defined.
module vx_alu_unit
  import VX_gpu_pkg::*;
#(
  parameter int unsigned CORE_ID = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  // request
  input  logic                        alu_req_valid_i,
  input  logic [UuidW-1:0]            alu_req_uuid_i,
  input  logic [WidW-1:0]             alu_req_wid_i,
  input  logic [NumThreads-1:0]       alu_req_tmask_i,
  input  logic [31:0]                 alu_req_pc_i,
  input  logic [31:0]                 alu_req_next_pc_i,
  input  logic [OpTypeW-1:0]          alu_req_op_type_i,
  input  logic [OpModW-1:0]           alu_req_op_mod_i,
  input  logic                        alu_req_use_pc_i,
  input  logic                        alu_req_use_imm_i,
  input  logic [31:0]                 alu_req_imm_i,
  input  logic [TidW-1:0]             alu_req_tid_i,
  input  logic [NumThreads-1:0][31:0] alu_req_rs1_data_i,
  input  logic [NumThreads-1:0][31:0] alu_req_rs2_data_i,
  input  logic [RegW-1:0]             alu_req_rd_i,
  input  logic                        alu_req_wb_i,
  output logic                        alu_req_ready_o,
  // commit
  output logic                        alu_commit_valid_o,
  output logic [UuidW-1:0]            alu_commit_uuid_o,
  output logic [WidW-1:0]             alu_commit_wid_o,
  output logic [NumThreads-1:0]       alu_commit_tmask_o,
  output logic [31:0]                 alu_commit_pc_o,
  output logic [NumThreads-1:0][31:0] alu_commit_data_o,
  output logic [RegW-1:0]             alu_commit_rd_o,
  output logic                        alu_commit_wb_o,
  output logic                        alu_commit_eop_o,
  input  logic                        alu_commit_ready_i,
  // branch control
  output logic                        branch_ctl_valid_o,
  output logic [WidW-1:0]             branch_ctl_wid_o,
  output logic                        branch_ctl_taken_o,
  output logic [31:0]                 branch_ctl_dest_o
);

  logic stall;
  logic is_br_op;
  logic unused_req;

  logic [NumThreads-1:0][31:0] alu_res;
  alu_stage_t                  s1_in, s1_q, s2_q;
  logic                        s1_valid, s2_valid;

  assign stall           = alu_commit_valid_o && !alu_commit_ready_i;
  assign alu_req_ready_o = !stall;
  assign is_br_op        = alu_req_op_mod_i[BrSelBit];

  // Per-lane integer datapath
  for (genvar i = 0; i < NumThreads; i++) begin : g_lane
    logic [31:0] opa, opb, lane_res;

    assign opa = alu_req_use_pc_i  ? alu_req_pc_i  : alu_req_rs1_data_i[i];
    assign opb = alu_req_use_imm_i ? alu_req_imm_i : alu_req_rs2_data_i[i];

    // Decode op_type into the lane result; unknown ops yield 0
    always_comb begin
      lane_res = '0;
      case (alu_req_op_type_i)
        INST_ALU_ADD:   lane_res = opa + opb;
        INST_ALU_SUB:   lane_res = opa - opb;
        INST_ALU_SLT:   lane_res = {31'b0, $signed(opa) < $signed(opb)};
        INST_ALU_SLTU:  lane_res = {31'b0, opa < opb};
        INST_ALU_XOR:   lane_res = opa ^ opb;
        INST_ALU_OR:    lane_res = opa | opb;
        INST_ALU_AND:   lane_res = opa & opb;
        INST_ALU_SLL:   lane_res = opa << opb[4:0];
        INST_ALU_SRL:   lane_res = opa >> opb[4:0];
        INST_ALU_SRA:   lane_res = $unsigned($signed(opa) >>> opb[4:0]);
        INST_ALU_LUI:   lane_res = alu_req_imm_i;
        INST_ALU_AUIPC: lane_res = alu_req_pc_i + alu_req_imm_i;
        default:        lane_res = '0;
      endcase
    end

    assign alu_res[i] = lane_res;
  end

`ifdef ALU_BRANCH_EN
  logic [31:0] br_a, br_b, br_dest;
  logic        br_known, br_taken, br_jmp;

  // Compare only the lane that owns the branch
  assign br_a = alu_req_rs1_data_i[alu_req_tid_i];
  assign br_b = alu_req_rs2_data_i[alu_req_tid_i];

  // Resolve branch outcome and target
  always_comb begin
    br_known = 1'b1;
    br_taken = 1'b0;
    br_jmp   = 1'b0;
    case (alu_req_op_type_i)
      INST_BR_BEQ:  br_taken = (br_a == br_b);
      INST_BR_BNE:  br_taken = (br_a != br_b);
      INST_BR_BLT:  br_taken = ($signed(br_a) <  $signed(br_b));
      INST_BR_BGE:  br_taken = ($signed(br_a) >= $signed(br_b));
      INST_BR_BLTU: br_taken = (br_a <  br_b);
      INST_BR_BGEU: br_taken = (br_a >= br_b);
      INST_BR_JAL, INST_BR_JALR: begin
        br_taken = 1'b1;
        br_jmp   = 1'b1;
      end
      default:      br_known = 1'b0;
    endcase
    if (!br_taken) begin
      br_dest = alu_req_next_pc_i;
    end else if (alu_req_op_type_i == INST_BR_JALR) begin
      br_dest = (br_a + alu_req_imm_i) & ~32'd1;
    end else begin
      br_dest = alu_req_pc_i + alu_req_imm_i;
    end
  end

  assign unused_req = ^alu_req_op_mod_i[OpModW-1:1];
`else
  assign unused_req = ^{alu_req_op_mod_i[OpModW-1:1], alu_req_tid_i, alu_req_next_pc_i};
`endif

  // Assemble the S1 payload from the request and the computed results
  always_comb begin
    s1_in           = '0;
    s1_in.res.data  = alu_res;
    s1_in.res.rd    = alu_req_rd_i;
    s1_in.res.wb    = alu_req_wb_i;
    s1_in.res.uuid  = alu_req_uuid_i;
    s1_in.res.wid   = alu_req_wid_i;
    s1_in.res.tmask = alu_req_tmask_i;
    s1_in.res.pc    = alu_req_pc_i;
    if (is_br_op) begin
      s1_in.res.data = '0;
`ifdef ALU_BRANCH_EN
      if (br_known) begin
        s1_in.is_br = 1'b1;
        s1_in.taken = br_taken;
        s1_in.dest  = br_dest;
        // Jumps write the link address; conditional branches write nothing
        if (br_jmp) begin
          s1_in.res.data = {NumThreads{alu_req_next_pc_i}};
        end else begin
          s1_in.res.wb = 1'b0;
        end
      end
`else
      s1_in.res.wb = 1'b0;
`endif
    end
  end

  VX_pipe_register #(
    .DataW ($bits(alu_stage_t))
  ) u_s1 (
    .clk_i    (clk),
    .reset_i  (reset),
    .enable_i (!stall),
    .valid_i  (alu_req_valid_i),
    .data_i   (s1_in),
    .valid_o  (s1_valid),
    .data_o   (s1_q)
  );

  VX_pipe_register #(
    .DataW ($bits(alu_stage_t))
  ) u_s2 (
    .clk_i    (clk),
    .reset_i  (reset),
    .enable_i (!stall),
    .valid_i  (s1_valid),
    .data_i   (s1_q),
    .valid_o  (s2_valid),
    .data_o   (s2_q)
  );

  assign alu_commit_valid_o = s2_valid;
  assign alu_commit_uuid_o  = s2_q.res.uuid;
  assign alu_commit_wid_o   = s2_q.res.wid;
  assign alu_commit_tmask_o = s2_q.res.tmask;
  assign alu_commit_pc_o    = s2_q.res.pc;
  assign alu_commit_data_o  = s2_q.res.data;
  assign alu_commit_rd_o    = s2_q.res.rd;
  assign alu_commit_wb_o    = s2_q.res.wb;
  assign alu_commit_eop_o   = 1'b1;

  // Branch pulse rides on the commit handshake; is_br is constant 0 without branch support
  assign branch_ctl_valid_o = s2_valid && s2_q.is_br && alu_commit_ready_i;
  assign branch_ctl_wid_o   = s2_q.res.wid;
  assign branch_ctl_taken_o = s2_q.taken;
  assign branch_ctl_dest_o  = s2_q.dest;

`ifndef SYNTHESIS
  logic req_op_known;
`ifdef ALU_BRANCH_EN
  assign req_op_known = is_br_op ? br_known : is_alu_op_known(alu_req_op_type_i);
`else
  assign req_op_known = is_br_op || is_alu_op_known(alu_req_op_type_i);
`endif

  a_known_op : assert property (@(posedge clk) disable iff (reset)
    (alu_req_valid_i && alu_req_ready_o) |-> req_op_known)
    else $error("vx_alu_unit[%0d]: unknown op_type %0h", CORE_ID, alu_req_op_type_i);

  a_nonzero_tmask : assert property (@(posedge clk) disable iff (reset)
    (alu_req_valid_i && alu_req_ready_o) |-> (alu_req_tmask_i != '0))
    else $error("vx_alu_unit[%0d]: request with empty tmask", CORE_ID);
`endif

endmodule
